ddr3_xfer_seq: RTL and testbench
================================

Name: ddr3_xfer_seq

Overview:
- Sits directly upstream of the ddr3 UI engine and drives its ibuf/obuf go/count/address ports.
- Accepts one host transfer command (DDR3 address, length, direction) and splits it into chunks of at most half a buffer.
- Ping-pongs the two buffer halves against an external buffer filler/drainer and releases each half when the UI engine finishes with it.
- Reports completion, and reports a fault with the failing chunk index.

Parameters:
- BUF_DEPTH, 10, buffer address width; half size HALF = 2**(BUF_DEPTH-1) words.
- MEM_ADDR_DEPTH, 28, DDR3 address width as presented to the UI engine.
- LEN_WIDTH, 24, width of the total transfer length in 32-bit words.

Ports:
- ui_clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_phy_init_done  in  1  DDR3 calibration complete.
- i_cmd_stb  in  1  command valid; accepted when o_cmd_rdy=1.
- o_cmd_rdy  out  1  idle and able to accept a command.
- i_cmd_wr  in  1  1 = buffer to DDR3 (write), 0 = DDR3 to buffer (read).
- i_cmd_addr  in  MEM_ADDR_DEPTH  DDR3 start address, in UI address units.
- i_cmd_len  in  LEN_WIDTH  total words; LSB ignored (forced even).
- o_done  out  1  one-cycle pulse at command end.
- o_fault  out  1  sticky fault; cleared on the next accepted command.
- o_fault_chunk  out  LEN_WIDTH  index of the chunk that faulted.
- i_half_ready  in  2  write: half h holds data; read: half h is free to fill.
- o_half_release  out  2  one-cycle pulse: half h consumed (write) or filled (read).
- o_half_len  out  BUF_DEPTH  word count of the chunk being released; valid with o_half_release.
- o_ibuf_go, o_obuf_go  out  1  one-cycle go pulses to the UI engine.
- o_xfer_count  out  BUF_DEPTH  chunk length; drives both the ibuf and obuf count inputs.
- o_buf_start  out  BUF_DEPTH  h*HALF; drives both ibuf start_addrb and obuf start_addra.
- o_ddr3_addr  out  MEM_ADDR_DEPTH  chunk DDR3 address; drives both ddr3 address inputs.
- i_ibuf_bsy, i_obuf_bsy, i_ibuf_ddr3_fault, i_obuf_ddr3_fault  in  1  status from the UI engine.

Behaviour:
- Reset values:
  - All outputs 0, except o_cmd_rdy, which is 0 during reset and becomes 1 in IDLE.
  - Internal state: half pointer h=0, state IDLE.
- States:
  - IDLE → ARM:
    - Taken on i_cmd_stb & o_cmd_rdy.
    - Latches direction, address, and remaining = len & ~1; clears o_fault and chunk index; h=0.
    - remaining==0: o_done pulses the next cycle and the block returns to IDLE; no go is issued.
  - ARM → GO:
    - Waits for i_phy_init_done & i_half_ready[h].
    - Computes chunk = min(remaining, HALF) and registers o_xfer_count=chunk, o_buf_start=h*HALF, o_ddr3_addr=current address.
    - o_xfer_count is BUF_DEPTH bits wide; chunk==HALF fits.
  - GO:
    - Asserts the selected go for exactly one cycle while count/start/addr are stable.
    - Next state: WAIT_BSY.
  - WAIT_BSY: requires the selected bsy to be seen high within 8 cycles of go, then low.
    - bsy never rises: fault.
    - bsy falls with its ddr3_fault=1: fault.
    - Otherwise → RELEASE.
  - RELEASE:
    - Pulses o_half_release[h] with o_half_len=chunk.
    - address += chunk>>1 (UI burst addressing, two words per address step), wrapping modulo 2**MEM_ADDR_DEPTH.
    - remaining -= chunk; chunk index += 1; h toggles.
    - remaining==0 → DONE; otherwise → ARM.
  - DONE: o_done pulses for one cycle → IDLE.
  - FAULT:
    - Sets o_fault and o_fault_chunk = chunk index; pulses o_done once → IDLE.
    - No release is issued for the faulted half.
- Go outputs are held low in every state except GO.
- Chunk address/count registers are unchanged from ARM exit through RELEASE.
- Stray inputs:
  - i_cmd_stb while busy is ignored.
  - i_half_ready bits for the non-current half are ignored.
- Reset asserted mid-transfer: everything aborts immediately; no release or done pulse; outputs return to reset values.
- Latency: accept to go is 2 cycles when init is done and the half is ready; last bsy fall to o_done is 2 cycles.

Test Plan:
- Write, len=1024, BUF_DEPTH=10, addr=0x100, both halves ready, UI model bsy=6 cycles → two chunks of 512, ddr3 addr 0x100 then 0x200, starts 0 then 512, releases [0] then [1], o_done once, o_fault=0.
- Read, len=1300 → chunks 512/512/276, halves 0,1,0; third chunk addr = base+512; o_half_len=276 on the final release.
- len=0 or len=1 → no go, o_done one cycle after accept, o_cmd_rdy back to 1.
- i_phy_init_done=0 for 50 cycles after accept → no go until it rises; go 1 cycle after the rise.
- Second chunk ends with i_obuf_ddr3_fault=1 → o_fault=1, o_fault_chunk=1, no release[1], o_done pulse; next command clears o_fault.
- bsy never asserted after go → fault at cycle 8; reset pulsed mid-chunk → all outputs 0, IDLE, no done.

Source files
------------

// File: rtl/ddr3_xfer_seq.sv
// ddr3_xfer_seq: splits one host transfer command into half-buffer chunks,
// ping-pongs the two buffer halves against an external filler/drainer and
// drives the go/count/address ports of the ddr3 UI engine for each chunk.
// Completion and faults (with the index of the failing chunk) are reported
// back to the host.
module ddr3_xfer_seq #(
  parameter int BUF_DEPTH      = 10,
  parameter int MEM_ADDR_DEPTH = 28,
  parameter int LEN_WIDTH      = 24
) (
  input  logic                      ui_clk,
  input  logic                      rst,
  input  logic                      i_phy_init_done,
  input  logic                      i_cmd_stb,
  output logic                      o_cmd_rdy,
  input  logic                      i_cmd_wr,
  input  logic [MEM_ADDR_DEPTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]      i_cmd_len,
  output logic                      o_done,
  output logic                      o_fault,
  output logic [LEN_WIDTH-1:0]      o_fault_chunk,
  input  logic [1:0]                i_half_ready,
  output logic [1:0]                o_half_release,
  output logic [BUF_DEPTH-1:0]      o_half_len,
  output logic                      o_ibuf_go,
  output logic                      o_obuf_go,
  output logic [BUF_DEPTH-1:0]      o_xfer_count,
  output logic [BUF_DEPTH-1:0]      o_buf_start,
  output logic [MEM_ADDR_DEPTH-1:0] o_ddr3_addr,
  input  logic                      i_ibuf_bsy,
  input  logic                      i_obuf_bsy,
  input  logic                      i_ibuf_ddr3_fault,
  input  logic                      i_obuf_ddr3_fault
);

  localparam int                   HALF   = 2 ** (BUF_DEPTH - 1);
  localparam logic [BUF_DEPTH-1:0] HALF_W = BUF_DEPTH'(HALF);
  // Number of WAIT_BSY cycles (minus one) allowed before bsy must have risen.
  localparam logic [2:0]           BSY_MISS_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_GO,
    S_WAIT_BSY,
    S_RELEASE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t                    state;
  state_t                    state_nx;
  logic                      rdy_q;
  logic                      dir_wr;
  logic [LEN_WIDTH-1:0]      remaining;
  logic [LEN_WIDTH-1:0]      rem_left;
  logic [LEN_WIDTH-1:0]      len_even;
  logic [MEM_ADDR_DEPTH-1:0] cur_addr;
  logic                      half_sel;
  logic [LEN_WIDTH-1:0]      chunk_idx;
  logic [2:0]                miss_cnt;
  logic                      bsy_seen;
  logic                      sel_bsy;
  logic                      sel_fault;
  logic                      cmd_acc;
  logic                      arm_go;

  // Chunk size clamps to one buffer half; a full half still fits BUF_DEPTH bits.
  function automatic logic [BUF_DEPTH-1:0] sat_chunk(input logic [LEN_WIDTH-1:0] rem);
    logic [BUF_DEPTH-1:0] c;
    c = (rem >= LEN_WIDTH'(HALF)) ? HALF_W : rem[BUF_DEPTH-1:0];
    return c;
  endfunction

  // UI addresses step once per two 32-bit words; wraps at the address width.
  function automatic logic [MEM_ADDR_DEPTH-1:0] next_addr(
    input logic [MEM_ADDR_DEPTH-1:0] a,
    input logic [BUF_DEPTH-1:0]      n
  );
    logic [MEM_ADDR_DEPTH-1:0] r;
    r = a + MEM_ADDR_DEPTH'(n >> 1);
    return r;
  endfunction

  assign o_cmd_rdy = rdy_q;
  assign len_even  = i_cmd_len & ~LEN_WIDTH'(1);
  assign cmd_acc   = i_cmd_stb & rdy_q;
  assign arm_go    = (state == S_ARM) & i_phy_init_done & i_half_ready[half_sel];
  assign sel_bsy   = dir_wr ? i_ibuf_bsy : i_obuf_bsy;
  assign sel_fault = dir_wr ? i_ibuf_ddr3_fault : i_obuf_ddr3_fault;
  assign rem_left  = remaining - LEN_WIDTH'(o_xfer_count);

  // State register; ready is registered so it stays low while reset is held.
  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nx;
      rdy_q <= (state_nx == S_IDLE);
    end
  end

  // Next-state decode and the single-cycle pulse outputs.
  always_comb begin
    state_nx       = state;
    o_ibuf_go      = 1'b0;
    o_obuf_go      = 1'b0;
    o_done         = 1'b0;
    o_half_release = 2'b00;
    o_half_len     = '0;
    case (state)
      S_IDLE: begin
        if (cmd_acc) state_nx = (len_even == '0) ? S_DONE : S_ARM;
      end
      S_ARM: begin
        if (arm_go) state_nx = S_GO;
      end
      S_GO: begin
        o_ibuf_go = dir_wr;
        o_obuf_go = ~dir_wr;
        state_nx  = S_WAIT_BSY;
      end
      S_WAIT_BSY: begin
        if (!bsy_seen) begin
          if (!sel_bsy && (miss_cnt == BSY_MISS_LAST)) state_nx = S_FAULT;
        end else if (!sel_bsy) begin
          state_nx = sel_fault ? S_FAULT : S_RELEASE;
        end
      end
      S_RELEASE: begin
        o_half_release[half_sel] = 1'b1;
        o_half_len               = o_xfer_count;
        state_nx                 = (rem_left == '0) ? S_DONE : S_ARM;
      end
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      S_FAULT: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command datapath: direction, running address and words still to move.
  always_ff @(posedge ui_clk) begin
    if (cmd_acc) begin
      dir_wr    <= i_cmd_wr;
      cur_addr  <= i_cmd_addr;
      remaining <= len_even;
    end else if (state == S_RELEASE) begin
      cur_addr  <= next_addr(cur_addr, o_xfer_count);
      remaining <= rem_left;
    end
  end

  // Half pointer and chunk index advance once per released chunk.
  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      half_sel  <= 1'b0;
      chunk_idx <= '0;
    end else if (cmd_acc) begin
      half_sel  <= 1'b0;
      chunk_idx <= '0;
    end else if (state == S_RELEASE) begin
      half_sel  <= ~half_sel;
      chunk_idx <= chunk_idx + LEN_WIDTH'(1);
    end
  end

  // Chunk descriptor presented to the UI engine; frozen from ARM exit to RELEASE.
  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      o_xfer_count <= '0;
      o_buf_start  <= '0;
      o_ddr3_addr  <= '0;
    end else if (arm_go) begin
      o_xfer_count <= sat_chunk(remaining);
      o_buf_start  <= half_sel ? HALF_W : '0;
      o_ddr3_addr  <= cur_addr;
    end
  end

  // Busy watchdog: bsy must rise within the miss window after go, then fall.
  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      miss_cnt <= '0;
      bsy_seen <= 1'b0;
    end else if (state == S_GO) begin
      miss_cnt <= '0;
      bsy_seen <= 1'b0;
    end else if ((state == S_WAIT_BSY) && !bsy_seen) begin
      if (sel_bsy) bsy_seen <= 1'b1;
      else         miss_cnt <= miss_cnt + 3'd1;
    end
  end

  // Sticky fault status, cleared by the next accepted command.
  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      o_fault       <= 1'b0;
      o_fault_chunk <= '0;
    end else if (cmd_acc) begin
      o_fault       <= 1'b0;
      o_fault_chunk <= '0;
    end else if ((state == S_WAIT_BSY) && (state_nx == S_FAULT)) begin
      o_fault       <= 1'b1;
      o_fault_chunk <= chunk_idx;
    end
  end

endmodule

// File: tb/tb_ddr3_xfer_seq.sv
// Testbench for ddr3_xfer_seq: a table of host commands with hand-computed
// chunk descriptors, release pattern, done cycle and fault status, plus
// directed sequences for init stall, half readiness and mid-transfer reset.
`timescale 1ns/1ps
module tb_ddr3_xfer_seq;
  localparam int BUF_DEPTH      = 10;
  localparam int MEM_ADDR_DEPTH = 28;
  localparam int LEN_WIDTH      = 24;
  localparam int NVEC           = 8;

  logic                      ui_clk = 1'b0;
  logic                      rst    = 1'b0;
  logic                      i_phy_init_done = 1'b1;
  logic                      i_cmd_stb = 1'b0;
  logic                      o_cmd_rdy;
  logic                      i_cmd_wr = 1'b0;
  logic [MEM_ADDR_DEPTH-1:0] i_cmd_addr = '0;
  logic [LEN_WIDTH-1:0]      i_cmd_len = '0;
  logic                      o_done;
  logic                      o_fault;
  logic [LEN_WIDTH-1:0]      o_fault_chunk;
  logic [1:0]                i_half_ready = 2'b11;
  logic [1:0]                o_half_release;
  logic [BUF_DEPTH-1:0]      o_half_len;
  logic                      o_ibuf_go, o_obuf_go;
  logic [BUF_DEPTH-1:0]      o_xfer_count, o_buf_start;
  logic [MEM_ADDR_DEPTH-1:0] o_ddr3_addr;
  logic                      i_ibuf_bsy = 1'b0, i_obuf_bsy = 1'b0;
  logic                      i_ibuf_ddr3_fault = 1'b0, i_obuf_ddr3_fault = 1'b0;

  always #5 ui_clk = ~ui_clk;

  ddr3_xfer_seq #(
    .BUF_DEPTH(BUF_DEPTH), .MEM_ADDR_DEPTH(MEM_ADDR_DEPTH), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .ui_clk(ui_clk), .rst(rst), .i_phy_init_done(i_phy_init_done),
    .i_cmd_stb(i_cmd_stb), .o_cmd_rdy(o_cmd_rdy), .i_cmd_wr(i_cmd_wr),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .o_done(o_done),
    .o_fault(o_fault), .o_fault_chunk(o_fault_chunk), .i_half_ready(i_half_ready),
    .o_half_release(o_half_release), .o_half_len(o_half_len),
    .o_ibuf_go(o_ibuf_go), .o_obuf_go(o_obuf_go), .o_xfer_count(o_xfer_count),
    .o_buf_start(o_buf_start), .o_ddr3_addr(o_ddr3_addr),
    .i_ibuf_bsy(i_ibuf_bsy), .i_obuf_bsy(i_obuf_bsy),
    .i_ibuf_ddr3_fault(i_ibuf_ddr3_fault), .i_obuf_ddr3_fault(i_obuf_ddr3_fault)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk(nm, {o_cmd_rdy, o_done, o_fault, o_fault_chunk, o_half_release, o_half_len,
             o_ibuf_go, o_obuf_go, o_xfer_count, o_buf_start, o_ddr3_addr}, '0);
  endtask

  // UI engine model: bsy one cycle after go, held 6 cycles; ddr3_fault on a chosen chunk.
  int model_go_idx   = 0;
  int model_fault_at = -1;
  bit model_nobsy    = 1'b0;

  initial begin : ui_model
    int idx;
    bit is_wr;
    forever begin
      @(negedge ui_clk);
      if (o_ibuf_go || o_obuf_go) begin
        is_wr = o_ibuf_go;
        idx   = model_go_idx;
        model_go_idx++;
        if (!model_nobsy) begin
          @(posedge ui_clk); #1;
          i_ibuf_ddr3_fault = 1'b0;
          i_obuf_ddr3_fault = 1'b0;
          if (is_wr) i_ibuf_bsy = 1'b1; else i_obuf_bsy = 1'b1;
          repeat (6) @(posedge ui_clk);
          #1;
          i_ibuf_bsy = 1'b0;
          i_obuf_bsy = 1'b0;
          if (idx == model_fault_at) begin
            if (is_wr) i_ibuf_ddr3_fault = 1'b1; else i_obuf_ddr3_fault = 1'b1;
          end
        end
      end
    end
  end

  // Observations collected per command.
  int                        n_go, n_rel, done_cyc, wrong_go;
  int                        g_cyc   [4];
  logic [BUF_DEPTH-1:0]      g_cnt   [4];
  logic [BUF_DEPTH-1:0]      g_start [4];
  logic [MEM_ADDR_DEPTH-1:0] g_addr  [4];
  logic [1:0]                r_mask  [4];
  logic [BUF_DEPTH-1:0]      r_len   [4];
  logic                      f_at_done;
  logic [LEN_WIDTH-1:0]      fc_at_done;

  task automatic issue(input bit wr, input logic [MEM_ADDR_DEPTH-1:0] a,
                       input logic [LEN_WIDTH-1:0] l);
    @(negedge ui_clk);
    chk("cmd_rdy_idle", o_cmd_rdy, 1'b1);
    model_go_idx = 0;
    i_cmd_stb  = 1'b1;
    i_cmd_wr   = wr;
    i_cmd_addr = a;
    i_cmd_len  = l;
    @(posedge ui_clk); #1;
    i_cmd_stb  = 1'b0;
  endtask

  // Cycle c is the c-th cycle after the accepting edge; sampled mid-cycle.
  task automatic collect(input int c0, input bit wr);
    n_go = 0; n_rel = 0; done_cyc = -1; wrong_go = 0;
    for (int c = c0; c < c0 + 400; c++) begin
      @(negedge ui_clk);
      if (o_ibuf_go || o_obuf_go) begin
        if (n_go < 4) begin
          g_cyc[n_go] = c; g_cnt[n_go] = o_xfer_count;
          g_start[n_go] = o_buf_start; g_addr[n_go] = o_ddr3_addr;
        end
        if (wr ? o_obuf_go : o_ibuf_go) wrong_go++;
        n_go++;
      end
      if (o_half_release != 2'b00) begin
        if (n_rel < 4) begin
          r_mask[n_rel] = o_half_release; r_len[n_rel] = o_half_len;
        end
        n_rel++;
      end
      if (o_done) begin
        done_cyc = c; f_at_done = o_fault; fc_at_done = o_fault_chunk;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic                      wr;
    logic [MEM_ADDR_DEPTH-1:0] addr;
    logic [LEN_WIDTH-1:0]      len;
    logic                      nobsy;
    int                        fault_at;
    int                        gos;
    logic [BUF_DEPTH-1:0]      c0, c1, c2;
    logic [BUF_DEPTH-1:0]      s0, s1, s2;
    logic [MEM_ADDR_DEPTH-1:0] a0, a1, a2;
    int                        rels;
    int                        done_cyc;
    logic                      fault;
    logic [LEN_WIDTH-1:0]      fchunk;
  } vec_t;

  vec_t tbl [NVEC];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [BUF_DEPTH-1:0]      e_cnt  [3];
    logic [BUF_DEPTH-1:0]      e_start[3];
    logic [MEM_ADDR_DEPTH-1:0] e_addr [3];
    logic prev_fault;
    vec_t v;
    int   cnt_go, cnt_rdy, cnt_done, cnt_rel;

    //        wr  addr          len       nobsy flt gos c0       c1       c2       s0     s1       s2     a0             a1            a2            rels done flt fchunk
    tbl[0] = '{1'b1, 28'h0000100, 24'd1024, 1'b0, -1, 2, 10'd512, 10'd512, 10'd0,   10'd0, 10'd512, 10'd0, 28'h0000100, 28'h0000200, 28'h0,       2, 21, 1'b0, 24'd0};
    tbl[1] = '{1'b0, 28'h0002000, 24'd1300, 1'b0, -1, 3, 10'd512, 10'd512, 10'd276, 10'd0, 10'd512, 10'd0, 28'h0002000, 28'h0002100, 28'h0002200, 3, 31, 1'b0, 24'd0};
    tbl[2] = '{1'b1, 28'h0000400, 24'd0,    1'b0, -1, 0, 10'd0,   10'd0,   10'd0,   10'd0, 10'd0,   10'd0, 28'h0,       28'h0,       28'h0,       0, 1,  1'b0, 24'd0};
    tbl[3] = '{1'b0, 28'h0000400, 24'd1,    1'b0, -1, 0, 10'd0,   10'd0,   10'd0,   10'd0, 10'd0,   10'd0, 28'h0,       28'h0,       28'h0,       0, 1,  1'b0, 24'd0};
    tbl[4] = '{1'b1, 28'hFFFFFFF, 24'd515,  1'b0, -1, 2, 10'd512, 10'd2,   10'd0,   10'd0, 10'd512, 10'd0, 28'hFFFFFFF, 28'h00000FF, 28'h0,       2, 21, 1'b0, 24'd0};
    tbl[5] = '{1'b0, 28'h0000040, 24'd2048, 1'b0,  1, 2, 10'd512, 10'd512, 10'd0,   10'd0, 10'd512, 10'd0, 28'h0000040, 28'h0000140, 28'h0,       1, 20, 1'b1, 24'd1};
    tbl[6] = '{1'b1, 28'h0000000, 24'd2,    1'b0, -1, 1, 10'd2,   10'd0,   10'd0,   10'd0, 10'd0,   10'd0, 28'h0,       28'h0,       28'h0,       1, 11, 1'b0, 24'd0};
    tbl[7] = '{1'b1, 28'h0000010, 24'd4,    1'b1, -1, 1, 10'd4,   10'd0,   10'd0,   10'd0, 10'd0,   10'd0, 28'h0000010, 28'h0,       28'h0,       0, 11, 1'b1, 24'd0};

    // Reset state: asynchronous, everything low including ready.
    #3;
    chk_zero_outputs("reset_outputs_async");
    repeat (2) @(posedge ui_clk);
    #1;
    chk_zero_outputs("reset_outputs_clocked");
    @(negedge ui_clk);
    rst = 1'b1;
    repeat (2) @(negedge ui_clk);
    chk("rdy_after_reset", o_cmd_rdy, 1'b1);

    prev_fault = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      v = tbl[i];
      e_cnt[0] = v.c0;   e_cnt[1] = v.c1;   e_cnt[2] = v.c2;
      e_start[0] = v.s0; e_start[1] = v.s1; e_start[2] = v.s2;
      e_addr[0] = v.a0;  e_addr[1] = v.a1;  e_addr[2] = v.a2;
      model_nobsy    = v.nobsy;
      model_fault_at = v.fault_at;
      chk($sformatf("v%0d_fault_sticky", i), o_fault, prev_fault);
      issue(v.wr, v.addr, v.len);
      collect(1, v.wr);
      chk($sformatf("v%0d_go_count", i), n_go, v.gos);
      chk($sformatf("v%0d_go_line", i), wrong_go, 0);
      if (v.gos > 0) chk($sformatf("v%0d_first_go_cycle", i), g_cyc[0], 2);
      for (int k = 0; k < v.gos && k < 3; k++) begin
        chk($sformatf("v%0d_c%0d_count", i, k), g_cnt[k], e_cnt[k]);
        chk($sformatf("v%0d_c%0d_start", i, k), g_start[k], e_start[k]);
        chk($sformatf("v%0d_c%0d_addr", i, k), g_addr[k], e_addr[k]);
      end
      chk($sformatf("v%0d_release_count", i), n_rel, v.rels);
      for (int k = 0; k < v.rels && k < 3; k++) begin
        chk($sformatf("v%0d_r%0d_half", i, k), r_mask[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("v%0d_r%0d_len", i, k), r_len[k], e_cnt[k]);
      end
      chk($sformatf("v%0d_done_cycle", i), done_cyc, v.done_cyc);
      chk($sformatf("v%0d_fault", i), f_at_done, v.fault);
      chk($sformatf("v%0d_fault_chunk", i), fc_at_done, v.fchunk);
      @(negedge ui_clk);
      chk($sformatf("v%0d_done_single", i), o_done, 1'b0);
      chk($sformatf("v%0d_rdy_back", i), o_cmd_rdy, 1'b1);
      prev_fault = v.fault;
    end

    // Calibration stall with a stray command held during the busy period.
    model_nobsy = 1'b0; model_fault_at = -1;
    i_phy_init_done = 1'b0;
    chk("init_fault_sticky", o_fault, prev_fault);
    issue(1'b1, 28'h0000ABC, 24'd8);
    i_cmd_stb = 1'b1; i_cmd_wr = 1'b0; i_cmd_addr = 28'h0000055; i_cmd_len = 24'd0;
    cnt_go = 0; cnt_rdy = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge ui_clk);
      if (o_ibuf_go || o_obuf_go) cnt_go++;
      if (o_cmd_rdy) cnt_rdy++;
    end
    i_cmd_stb = 1'b0;
    i_phy_init_done = 1'b1;
    chk("init_hold_no_go", cnt_go, 0);
    chk("busy_rdy_low", cnt_rdy, 0);
    collect(51, 1'b1);
    chk("init_go_count", n_go, 1);
    chk("init_go_cycle", g_cyc[0], 51);
    chk("init_go_line", wrong_go, 0);
    chk("init_count", g_cnt[0], 10'd8);
    chk("init_addr", g_addr[0], 28'h0000ABC);
    chk("init_done_cycle", done_cyc, 60);
    chk("init_fault_cleared", f_at_done, 1'b0);

    // Only the current half's ready bit matters.
    i_half_ready = 2'b10;
    issue(1'b0, 28'h0001000, 24'd6);
    cnt_go = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge ui_clk);
      if (o_ibuf_go || o_obuf_go) cnt_go++;
    end
    chk("other_half_no_go", cnt_go, 0);
    i_half_ready = 2'b01;
    collect(11, 1'b0);
    chk("half_go_cycle", g_cyc[0], 11);
    chk("half_count", g_cnt[0], 10'd6);
    chk("half_release", r_mask[0], 2'b01);
    chk("half_done_cycle", done_cyc, 20);
    i_half_ready = 2'b11;

    // Reset in the middle of a chunk: immediate abort, nothing emitted afterwards.
    issue(1'b1, 28'h0000300, 24'd1024);
    repeat (5) @(negedge ui_clk);
    chk("mid_go_count_before_reset", o_xfer_count, 10'd512);
    rst = 1'b0;
    #1;
    chk_zero_outputs("mid_reset_outputs_async");
    @(negedge ui_clk);
    chk_zero_outputs("mid_reset_outputs_held");
    rst = 1'b1;
    cnt_go = 0; cnt_done = 0; cnt_rel = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ui_clk);
      if (o_ibuf_go || o_obuf_go) cnt_go++;
      if (o_done) cnt_done++;
      if (o_half_release != 2'b00) cnt_rel++;
    end
    chk("post_reset_no_go", cnt_go, 0);
    chk("post_reset_no_done", cnt_done, 0);
    chk("post_reset_no_release", cnt_rel, 0);
    chk("post_reset_rdy", o_cmd_rdy, 1'b1);
    chk("post_reset_count", o_xfer_count, 10'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
